prom_loader: RTL

Writer side of the CPU program memory. Accepts a framed byte stream from a host link, assembles 15-bit instruction words, and writes them sequentially into the 16-entry instruction store that the fetch stage reads by program counter. It holds the CPU halted for the whole load session and reports completion or a framing/checksum error.

---
 rtl/prom_loader.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/prom_loader.sv
`default_nettype none
// ============================================================================
// Module      : prom_loader
// Description : Framed byte-stream loader for the CPU instruction store.
//               Holds the CPU halted during a load session.
// Revision    : 1.0 - initial release
// ============================================================================
module prom_loader #(
    parameter int WORDS  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              CLK_LD,
    input  logic              RESET,
    input  logic              LD_START,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VALID,
    output logic              RX_READY,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [14:0]       WR_DATA,
    output logic              CPU_HALT,
    output logic              LD_DONE,
    output logic              LD_ERR
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_CSUM  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [7:0]      C_MAX_N   = 8'(WORDS);
    localparam logic [ADDR_W:0] C_IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t              r_state;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W:0]     r_idx;
    logic [7:0]          r_sum;
    logic [6:0]          r_hi;
    logic                r_rx_ready;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [14:0]         r_wr_data;
    logic                r_cpu_halt;
    logic                r_ld_done;
    logic                r_ld_err;

    state_t              w_state_nx;
    logic [ADDR_W:0]     w_count_nx;
    logic [ADDR_W:0]     w_idx_nx;
    logic [ADDR_W:0]     w_idx_inc;
    logic [7:0]          w_sum_nx;
    logic [7:0]          w_sum_add;
    logic [6:0]          w_hi_nx;
    logic                w_wr_en_nx;
    logic [ADDR_W-1:0]   w_wr_addr_nx;
    logic [14:0]         w_wr_data_nx;
    logic                w_ld_done_nx;
    logic                w_rx_ready_nx;
    logic                w_cpu_halt_nx;
    logic                w_ld_err_nx;
    logic                w_accept;

    // Ready is registered and tracks the byte-accepting states exactly.
    assign w_accept = RX_VALID & r_rx_ready;

    always_comb begin
        w_state_nx   = r_state;
        w_count_nx   = r_count;
        w_idx_nx     = r_idx;
        w_sum_nx     = r_sum;
        w_hi_nx      = r_hi;
        w_wr_en_nx   = 1'b0;
        w_wr_addr_nx = r_wr_addr;
        w_wr_data_nx = r_wr_data;
        w_ld_done_nx = 1'b0;
        w_sum_add    = r_sum + RX_DATA;
        w_idx_inc    = r_idx + C_IDX_ONE;

        case (r_state)
            S_IDLE, S_ERR: begin
                if (LD_START) begin
                    w_state_nx = S_COUNT;
                end
            end
            S_COUNT: begin
                if (w_accept) begin
                    if (RX_DATA == 8'd0 || RX_DATA > C_MAX_N) begin
                        w_state_nx = S_ERR;
                    end else begin
                        w_count_nx = RX_DATA[ADDR_W:0];
                        w_idx_nx   = '0;
                        w_sum_nx   = RX_DATA;
                        w_state_nx = S_HI;
                    end
                end
            end
            S_HI: begin
                if (w_accept) begin
                    if (RX_DATA[7]) begin
                        w_state_nx = S_ERR;
                    end else begin
                        w_hi_nx    = RX_DATA[6:0];
                        w_sum_nx   = w_sum_add;
                        w_state_nx = S_LO;
                    end
                end
            end
            S_LO: begin
                if (w_accept) begin
                    w_wr_en_nx   = 1'b1;
                    w_wr_addr_nx = r_idx[ADDR_W-1:0];
                    w_wr_data_nx = {r_hi, RX_DATA};
                    w_idx_nx     = w_idx_inc;
                    w_sum_nx     = w_sum_add;
                    w_state_nx   = (w_idx_inc == r_count) ? S_CSUM : S_HI;
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    if (w_sum_add == 8'd0) begin
                        w_ld_done_nx = 1'b1;
                        w_state_nx   = S_IDLE;
                    end else begin
                        w_state_nx   = S_ERR;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // Status outputs are registered copies of the upcoming state.
        w_rx_ready_nx = (w_state_nx == S_COUNT) || (w_state_nx == S_HI) ||
                        (w_state_nx == S_LO)    || (w_state_nx == S_CSUM);
        w_cpu_halt_nx = (w_state_nx != S_IDLE);
        w_ld_err_nx   = (w_state_nx == S_ERR);
    end

    always_ff @(posedge CLK_LD) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_idx      <= '0;
            r_sum      <= '0;
            r_hi       <= '0;
            r_rx_ready <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_cpu_halt <= 1'b0;
            r_ld_done  <= 1'b0;
            r_ld_err   <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_count    <= w_count_nx;
            r_idx      <= w_idx_nx;
            r_sum      <= w_sum_nx;
            r_hi       <= w_hi_nx;
            r_rx_ready <= w_rx_ready_nx;
            r_wr_en    <= w_wr_en_nx;
            r_wr_addr  <= w_wr_addr_nx;
            r_wr_data  <= w_wr_data_nx;
            r_cpu_halt <= w_cpu_halt_nx;
            r_ld_done  <= w_ld_done_nx;
            r_ld_err   <= w_ld_err_nx;
        end
    end

    assign RX_READY = r_rx_ready;
    assign WR_EN    = r_wr_en;
    assign WR_ADDR  = r_wr_addr;
    assign WR_DATA  = r_wr_data;
    assign CPU_HALT = r_cpu_halt;
    assign LD_DONE  = r_ld_done;
    assign LD_ERR   = r_ld_err;

endmodule
`default_nettype wire
